// File: rtl/vproc_result_seq_pkg.sv
// Shared types and helpers for the empty-result in-order sequencer.
// Optional build macro used by the sequencer: VPROC_RESULT_SEQ_BYPASS_EN.
package vproc_result_seq_pkg;

    localparam int unsigned RS_ID_W = 3;

    typedef struct packed {
        logic               valid;
        logic               done;
        logic [RS_ID_W-1:0] id;
    } result_seq_entry_t;

    function automatic int unsigned ptr_wrap_inc(int unsigned ptr, int unsigned depth);
        return (ptr + 1) % depth;
    endfunction

endpackage

// File: rtl/vproc_result_seq_if.sv
// Issue, completion and empty-result handshake bundle of the result sequencer.
interface vproc_result_seq_if #(
    parameter int unsigned XIF_ID_W = 3,
    parameter int unsigned PIPE_CNT = 2
);
    import vproc_result_seq_pkg::*;

    logic                         issue_valid;
    logic                         issue_ready;
    logic [XIF_ID_W-1:0]          issue_id;
    logic [PIPE_CNT-1:0]          done_valid;
    logic [PIPE_CNT*XIF_ID_W-1:0] done_id;
    logic                         result_empty_valid;
    logic                         result_empty_ready;
    logic [XIF_ID_W-1:0]          result_empty_id;

    modport master (
        output issue_valid, issue_id, done_valid, done_id, result_empty_ready,
        input  issue_ready, result_empty_valid, result_empty_id
    );

    modport slave (
        input  issue_valid, issue_id, done_valid, done_id, result_empty_ready,
        output issue_ready, result_empty_valid, result_empty_id
    );

endinterface

// File: rtl/vproc_result_seq.sv
// In-order sequencer presenting empty results in issue order from out-of-order completions.
// Define VPROC_RESULT_SEQ_BYPASS_EN to accept an issue into a full buffer in the cycle of a pop.
module vproc_result_seq
    import vproc_result_seq_pkg::*;
#(
    parameter int unsigned XIF_ID_W = 3,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned PIPE_CNT = 2
) (
    input  logic                         clk_i,
    input  logic                         async_rst_ni,
    input  logic                         sync_rst_ni,
    vproc_result_seq_if.slave            bus,
    output logic [$clog2(DEPTH+1)-1:0]   pending_cnt_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic                valid;
        logic                done;
        logic [XIF_ID_W-1:0] id;
    } entry_t;

    entry_t [DEPTH-1:0]               entry_q, entry_d;
    logic   [PTR_W-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic   [CNT_W-1:0]               cnt_q, cnt_d;
    logic   [DEPTH-1:0][PIPE_CNT-1:0] hit;
    logic                             push, pop, head_valid;

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        for (genvar p = 0; p < PIPE_CNT; p++) begin : g_pipe
            assign hit[i][p] = bus.done_valid[p] & entry_q[i].valid &
                               (entry_q[i].id == bus.done_id[p*XIF_ID_W +: XIF_ID_W]);
        end
    end

    // Head state comes straight from the entry flops, so no input reaches these outputs.
    assign head_valid             = entry_q[rd_ptr_q].valid;
    assign bus.result_empty_valid = head_valid & entry_q[rd_ptr_q].done;
    assign bus.result_empty_id    = head_valid ? entry_q[rd_ptr_q].id : '0;
    assign pending_cnt_o          = cnt_q;

`ifdef VPROC_RESULT_SEQ_BYPASS_EN
    assign bus.issue_ready = (cnt_q < CNT_W'(DEPTH)) |
                             (bus.result_empty_valid & bus.result_empty_ready);
`else
    assign bus.issue_ready = (cnt_q < CNT_W'(DEPTH));
`endif

    assign push = bus.issue_valid & bus.issue_ready;
    assign pop  = bus.result_empty_valid & bus.result_empty_ready;

    always_comb begin
        entry_d  = entry_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (|hit[i]) entry_d[i].done = 1'b1;
        end
        if (pop) begin
            entry_d[rd_ptr_q].valid = 1'b0;
            rd_ptr_d = PTR_W'(ptr_wrap_inc(32'(rd_ptr_q), DEPTH));
        end
        // Push last: in a full bypass cycle the write slot is the one being popped.
        if (push) begin
            entry_d[wr_ptr_q] = '{valid: 1'b1, done: 1'b0, id: bus.issue_id};
            wr_ptr_d = PTR_W'(ptr_wrap_inc(32'(wr_ptr_q), DEPTH));
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        if (!sync_rst_ni) begin
            entry_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            entry_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            entry_q  <= entry_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef VPROC_SVA
`ifndef VPROC_RESULT_SEQ_BYPASS_EN
    a_no_push_full: assert property (@(posedge clk_i) disable iff (!async_rst_ni || !sync_rst_ni)
        !(bus.issue_valid && cnt_q == CNT_W'(DEPTH)));
`endif
    for (genvar i = 0; i < DEPTH; i++) begin : g_sva_uniq
        a_unique_id: assert property (@(posedge clk_i) disable iff (!async_rst_ni || !sync_rst_ni)
            !(push && entry_q[i].valid && entry_q[i].id == bus.issue_id &&
              !(pop && rd_ptr_q == PTR_W'(i))));
    end
    for (genvar p = 0; p < PIPE_CNT; p++) begin : g_sva_done
        logic [DEPTH-1:0] match;
        for (genvar i = 0; i < DEPTH; i++) begin : g_m
            assign match[i] = hit[i][p];
        end
        a_done_match: assert property (@(posedge clk_i) disable iff (!async_rst_ni || !sync_rst_ni)
            bus.done_valid[p] |-> |match);
    end
    a_out_stable: assert property (@(posedge clk_i) disable iff (!async_rst_ni || !sync_rst_ni)
        (bus.result_empty_valid && !bus.result_empty_ready) |=>
        ($stable(bus.result_empty_valid) && $stable(bus.result_empty_id)));
`endif

endmodule

// File: tb/tb_vproc_result_seq.sv
// Self-checking bench for vproc_result_seq against a queue-based program-order model.
module tb_vproc_result_seq;

    localparam int unsigned W     = 3;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PIPES = 2;
    localparam int unsigned CW    = $clog2(DEPTH+1);

    logic          clk    = 1'b0;
    logic          arst_n = 1'b0;
    logic          srst_n = 1'b1;
    logic [CW-1:0] pending_cnt;
    int            n_chk  = 0;
    int            n_fail = 0;
    int            cyc    = 0;

    vproc_result_seq_if #(.XIF_ID_W(W), .PIPE_CNT(PIPES)) bus ();

    vproc_result_seq #(.XIF_ID_W(W), .DEPTH(DEPTH), .PIPE_CNT(PIPES)) dut (
        .clk_i        (clk),
        .async_rst_ni (arst_n),
        .sync_rst_ni  (srst_n),
        .bus          (bus),
        .pending_cnt_o(pending_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: outstanding instructions in program order with their done flag.
    typedef struct { logic [W-1:0] id; bit done; } ent_t;
    ent_t         mq[$];
    logic [W-1:0] seen[$];
    int           seen_cyc[$];

    function automatic bit m_valid();
        return mq.size() > 0 && mq[0].done;
    endfunction

    function automatic logic [W-1:0] m_id();
        return mq.size() > 0 ? mq[0].id : '0;
    endfunction

    function automatic bit m_ready();
`ifdef VPROC_RESULT_SEQ_BYPASS_EN
        return mq.size() < DEPTH || (m_valid() && bus.result_empty_ready);
`else
        return mq.size() < DEPTH;
`endif
    endfunction

    function automatic bit in_mq(input logic [W-1:0] id);
        foreach (mq[i]) if (mq[i].id == id) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [W+CW+1:0] obs();
        return {bus.result_empty_valid, bus.result_empty_id, pending_cnt, bus.issue_ready};
    endfunction

    function automatic logic [W+CW+1:0] model_vec();
        return {m_valid(), m_id(), CW'(mq.size()), m_ready()};
    endfunction

    task automatic model_update();
        bit   pop_m, push_m;
        ent_t e;
        if (!srst_n) begin
            mq.delete();
            return;
        end
        pop_m  = m_valid() && bus.result_empty_ready;
        push_m = bus.issue_valid && m_ready();
        for (int p = 0; p < PIPES; p++) begin
            if (bus.done_valid[p]) begin
                foreach (mq[i]) if (mq[i].id == bus.done_id[p*W +: W]) mq[i].done = 1'b1;
            end
        end
        if (pop_m) void'(mq.pop_front());
        if (push_m) begin
            e.id   = bus.issue_id;
            e.done = 1'b0;
            mq.push_back(e);
        end
    endtask

    task automatic drive(input bit iv, input logic [W-1:0] iid, input logic [PIPES-1:0] dv,
                         input logic [W-1:0] d0, input logic [W-1:0] d1, input bit rdy);
        bus.issue_valid        = iv;
        bus.issue_id           = iid;
        bus.done_valid         = dv;
        bus.done_id            = {d1, d0};
        bus.result_empty_ready = rdy;
    endtask

    task automatic step();
        if (bus.result_empty_valid && bus.result_empty_ready) begin
            seen.push_back(bus.result_empty_id);
            seen_cyc.push_back(cyc);
        end
        model_update();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        #12;
        n_chk++;
        if (bus.result_empty_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.result_empty_valid); end
        n_chk++;
        if (bus.result_empty_id !== '0) begin n_fail++; $display("FAIL reset_id got %0d want 0", bus.result_empty_id); end
        n_chk++;
        if (pending_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", pending_cnt); end
        n_chk++;
        if (bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", bus.issue_ready); end
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        mq.delete();
    endtask

    task automatic test_in_order();
        logic [W-1:0] exp_ids[3] = '{3'd1, 3'd2, 3'd3};
        int base;
        seen.delete(); seen_cyc.delete(); base = cyc;
        for (int c = 0; c < 8; c++) begin
            case (c)
                0, 1, 2: drive(1'b1, W'(c + 1), 2'b00, 3'd0, 3'd0, 1'b1);
                3, 4, 5: drive(1'b0, 3'd0, 2'b01, W'(c - 2), 3'd0, 1'b1);
                default: drive(1'b0, 3'd0, 2'b00, 3'd0, 3'd0, 1'b1);
            endcase
            n_chk++;
            if (obs() !== model_vec()) begin n_fail++; $display("FAIL in_order c%0d v/id/cnt/rdy got %b want %b", c, obs(), model_vec()); end
            step();
        end
        n_chk++;
        if (seen.size() != 3) begin n_fail++; $display("FAIL in_order_pops got %0d want 3", seen.size()); end
        for (int k = 0; k < 3 && k < seen.size(); k++) begin
            n_chk++;
            if (seen[k] !== exp_ids[k] || seen_cyc[k] - base != 4 + k) begin
                n_fail++; $display("FAIL in_order_id%0d got id %0d @c%0d want id %0d @c%0d", k, seen[k], seen_cyc[k] - base, exp_ids[k], 4 + k);
            end
        end
        n_chk++;
        if (pending_cnt !== '0) begin n_fail++; $display("FAIL in_order_cnt got %0d want 0", pending_cnt); end
    endtask

    task automatic test_out_of_order();
        logic [W-1:0] exp_ids[3] = '{3'd4, 3'd5, 3'd6};
        int base;
        seen.delete(); seen_cyc.delete(); base = cyc;
        for (int c = 0; c < 10; c++) begin
            case (c)
                0, 1, 2: drive(1'b1, W'(c + 4), 2'b00, 3'd0, 3'd0, 1'b1);
                3:       drive(1'b0, 3'd0, 2'b10, 3'd0, 3'd6, 1'b1);
                4:       drive(1'b0, 3'd0, 2'b10, 3'd0, 3'd5, 1'b1);
                5:       drive(1'b0, 3'd0, 2'b01, 3'd4, 3'd0, 1'b1);
                default: drive(1'b0, 3'd0, 2'b00, 3'd0, 3'd0, 1'b1);
            endcase
            if (c < 6) begin
                n_chk++;
                if (bus.result_empty_valid !== 1'b0) begin n_fail++; $display("FAIL ooo_early_valid c%0d got %b want 0", c, bus.result_empty_valid); end
            end
            n_chk++;
            if (obs() !== model_vec()) begin n_fail++; $display("FAIL ooo c%0d v/id/cnt/rdy got %b want %b", c, obs(), model_vec()); end
            step();
        end
        n_chk++;
        if (seen.size() != 3) begin n_fail++; $display("FAIL ooo_pops got %0d want 3", seen.size()); end
        for (int k = 0; k < 3 && k < seen.size(); k++) begin
            n_chk++;
            if (seen[k] !== exp_ids[k] || seen_cyc[k] - base != 6 + k) begin
                n_fail++; $display("FAIL ooo_id%0d got id %0d @c%0d want id %0d @c%0d", k, seen[k], seen_cyc[k] - base, exp_ids[k], 6 + k);
            end
        end
    endtask

    task automatic test_backpressure();
        int base;
        seen.delete(); seen_cyc.delete(); base = cyc;
        for (int c = 0; c < 9; c++) begin
            case (c)
                0:       drive(1'b1, 3'd2, 2'b00, 3'd0, 3'd0, 1'b0);
                1:       drive(1'b0, 3'd0, 2'b01, 3'd2, 3'd0, 1'b0);
                7, 8:    drive(1'b0, 3'd0, 2'b00, 3'd0, 3'd0, 1'b1);
                default: drive(1'b0, 3'd0, 2'b00, 3'd0, 3'd0, 1'b0);
            endcase
            if (c >= 2 && c <= 7) begin
                n_chk++;
                if (bus.result_empty_valid !== 1'b1 || bus.result_empty_id !== 3'd2) begin
                    n_fail++; $display("FAIL bp_hold c%0d got v%b id%0d want v1 id2", c, bus.result_empty_valid, bus.result_empty_id);
                end
            end
            n_chk++;
            if (obs() !== model_vec()) begin n_fail++; $display("FAIL bp c%0d v/id/cnt/rdy got %b want %b", c, obs(), model_vec()); end
            step();
        end
        n_chk++;
        if (seen.size() != 1 || seen_cyc[0] - base != 7) begin
            n_fail++; $display("FAIL bp_pop got %0d pops first @c%0d want 1 pop @c7", seen.size(), seen.size() > 0 ? seen_cyc[0] - base : -1);
        end
    endtask

    task automatic test_full();
        logic [W-1:0] exp_ids[5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd7};
        int acc_c = -1;
`ifdef VPROC_RESULT_SEQ_BYPASS_EN
        int exp_acc = 5;
`else
        int exp_acc = 6;
`endif
        seen.delete(); seen_cyc.delete();
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, W'(c), 2'b00, 3'd0, 3'd0, 1'b0);
            n_chk++;
            if (obs() !== model_vec()) begin n_fail++; $display("FAIL full_fill c%0d v/id/cnt/rdy got %b want %b", c, obs(), model_vec()); end
            step();
        end
        drive(1'b0, 3'd0, 2'b01, 3'd0, 3'd0, 1'b1);
        n_chk++;
        if (bus.issue_ready !== 1'b0 || pending_cnt !== CW'(4)) begin
            n_fail++; $display("FAIL full_stall got rdy%b cnt%0d want rdy0 cnt4", bus.issue_ready, pending_cnt);
        end
        step();
        for (int c = 5; c < 14; c++) begin
            if (acc_c < 0)            drive(1'b1, 3'd7, 2'b00, 3'd0, 3'd0, 1'b1);
            else if (c == acc_c + 1)  drive(1'b0, 3'd0, 2'b11, 3'd1, 3'd2, 1'b1);
            else if (c == acc_c + 2)  drive(1'b0, 3'd0, 2'b11, 3'd3, 3'd7, 1'b1);
            else                      drive(1'b0, 3'd0, 2'b00, 3'd0, 3'd0, 1'b1);
            if (acc_c >= 0 && c == acc_c + 1) begin
                n_chk++;
                if (pending_cnt !== CW'(4)) begin n_fail++; $display("FAIL full_cnt_after got %0d want 4", pending_cnt); end
            end
            n_chk++;
            if (obs() !== model_vec()) begin n_fail++; $display("FAIL full c%0d v/id/cnt/rdy got %b want %b", c, obs(), model_vec()); end
            if (acc_c < 0 && bus.issue_ready === 1'b1) acc_c = c;
            step();
        end
        n_chk++;
        if (acc_c != exp_acc) begin n_fail++; $display("FAIL full_accept_cycle got %0d want %0d", acc_c, exp_acc); end
        n_chk++;
        if (seen.size() != 5) begin n_fail++; $display("FAIL full_pops got %0d want 5", seen.size()); end
        for (int k = 0; k < 5 && k < seen.size(); k++) begin
            n_chk++;
            if (seen[k] !== exp_ids[k]) begin n_fail++; $display("FAIL full_id%0d got %0d want %0d", k, seen[k], exp_ids[k]); end
        end
    endtask

    task automatic test_wrap();
        logic [W-1:0] issued[$];
        logic [W-1:0] ids[3];
        int           ord[3];
        int           j, t;
        seen.delete(); seen_cyc.delete();
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < 3; k++) begin
                ids[k] = W'((3 * r + k) % 8);
                ord[k] = k;
            end
            for (int k = 2; k > 0; k--) begin
                j = $urandom_range(0, k);
                t = ord[k]; ord[k] = ord[j]; ord[j] = t;
            end
            for (int c = 0; c < 12; c++) begin
                if (c < 3) begin
                    drive(1'b1, ids[c], 2'b00, 3'd0, 3'd0, 1'b1);
                    issued.push_back(ids[c]);
                end else if (c < 6) begin
                    if ($urandom_range(0, 1) == 0) drive(1'b0, 3'd0, 2'b01, ids[ord[c-3]], 3'd0, 1'b1);
                    else                           drive(1'b0, 3'd0, 2'b10, 3'd0, ids[ord[c-3]], 1'b1);
                end else begin
                    drive(1'b0, 3'd0, 2'b00, 3'd0, 3'd0, 1'b1);
                end
                n_chk++;
                if (obs() !== model_vec() || pending_cnt > CW'(3)) begin
                    n_fail++; $display("FAIL wrap r%0d c%0d v/id/cnt/rdy got %b want %b", r, c, obs(), model_vec());
                end
                step();
                if (c >= 6 && mq.size() == 0) break;
            end
        end
        n_chk++;
        if (seen.size() != issued.size()) begin n_fail++; $display("FAIL wrap_pops got %0d want %0d", seen.size(), issued.size()); end
        for (int k = 0; k < issued.size() && k < seen.size(); k++) begin
            n_chk++;
            if (seen[k] !== issued[k]) begin n_fail++; $display("FAIL wrap_order%0d got %0d want %0d", k, seen[k], issued[k]); end
        end
    endtask

    task automatic test_reset_mid();
        for (int pass = 0; pass < 2; pass++) begin
            for (int c = 0; c < 4; c++) begin
                if (c < 3) drive(1'b1, W'(c + 1), 2'b00, 3'd0, 3'd0, 1'b0);
                else       drive(1'b0, 3'd0, 2'b01, 3'd2, 3'd0, 1'b0);
                step();
            end
            if (pass == 0) begin
                srst_n = 1'b0;
                drive(1'b0, 3'd0, 2'b01, 3'd1, 3'd0, 1'b0);
                step();
                srst_n = 1'b1;
                drive(1'b0, 3'd0, 2'b00, 3'd0, 3'd0, 1'b0);
            end else begin
                drive(1'b0, 3'd0, 2'b00, 3'd0, 3'd0, 1'b0);
                #3;
                arst_n = 1'b0;
                mq.delete();
                #1;
            end
            n_chk++;
            if (bus.result_empty_valid !== 1'b0 || pending_cnt !== '0 || bus.issue_ready !== 1'b1) begin
                n_fail++; $display("FAIL rst%0d_clear got v%b cnt%0d rdy%b want v0 cnt0 rdy1", pass, bus.result_empty_valid, pending_cnt, bus.issue_ready);
            end
            if (pass == 1) begin
                @(negedge clk);
                arst_n = 1'b1;
                @(posedge clk);
                #1;
            end
            drive(1'b0, 3'd0, 2'b01, 3'd2, 3'd0, 1'b1);
            step();
            for (int c = 0; c < 4; c++) begin
                if (c == 0) drive(1'b1, 3'd2, 2'b00, 3'd0, 3'd0, 1'b1);
                else        drive(1'b0, 3'd0, 2'b00, 3'd0, 3'd0, 1'b1);
                if (c > 0) begin
                    n_chk++;
                    if (bus.result_empty_valid !== 1'b0 || pending_cnt !== CW'(1)) begin
                        n_fail++; $display("FAIL rst%0d_stale_done c%0d got v%b cnt%0d want v0 cnt1", pass, c, bus.result_empty_valid, pending_cnt);
                    end
                end
                step();
            end
            drive(1'b0, 3'd0, 2'b01, 3'd2, 3'd0, 1'b1);
            step();
            drive(1'b0, 3'd0, 2'b00, 3'd0, 3'd0, 1'b1);
            n_chk++;
            if (obs() !== model_vec()) begin n_fail++; $display("FAIL rst%0d_after v/id/cnt/rdy got %b want %b", pass, obs(), model_vec()); end
            step();
        end
    endtask

    task automatic test_random();
        bit               iv, rdy;
        logic [W-1:0]     iid;
        logic [PIPES-1:0] dv;
        logic [W-1:0]     d[PIPES];
        for (int c = 0; c < 400; c++) begin
            iv  = 1'($urandom_range(0, 1));
            iid = W'($urandom_range(0, 7));
            if (in_mq(iid)) iv = 1'b0;
            dv = '0;
            for (int p = 0; p < PIPES; p++) begin
                d[p] = '0;
                if (mq.size() > 0 && $urandom_range(0, 2) == 0) begin
                    dv[p] = 1'b1;
                    d[p]  = mq[$urandom_range(0, mq.size() - 1)].id;
                end
            end
            rdy = ($urandom_range(0, 3) != 0);
            drive(iv, iid, dv, d[0], d[1], rdy);
            n_chk++;
            if (obs() !== model_vec()) begin n_fail++; $display("FAIL random c%0d v/id/cnt/rdy got %b want %b", c, obs(), model_vec()); end
            step();
        end
    endtask

    initial begin
        drive(1'b0, 3'd0, 2'b00, 3'd0, 3'd0, 1'b0);
        test_reset();
        test_in_order();
        test_out_of_order();
        test_backpressure();
        test_full();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
